mod_up_down_counter: RTL and testbench

MOD_UP_DOWN_COUNTER -- requirements
Module: mod_up_down_counter

---
 rtl/mod_up_down_counter.sv | 98 +++++++++
 tb/tb_mod_up_down_counter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mod_up_down_counter.sv
// Prescaled up/down counter with run-time limit, wrap or saturate at the bounds, and sticky ovf/unf flags.
// All outputs are registered; a step lands on the edge where the prescaler terminates; no backpressure.
module mod_up_down_counter #(
   parameter int N        = 8,
   parameter int PRESCALE = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         up_down,
   input  logic         mode,
   input  logic         load,
   input  logic [N-1:0] load_val,
   input  logic [N-1:0] limit,
   input  logic         clr_flags,
   output logic [N-1:0] count,
   output logic         tc,
   output logic         ovf,
   output logic         unf
);

   localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

   logic [PW-1:0] pre_q,   pre_d;
   logic [N-1:0]  count_q, count_d;
   logic          tc_q,    tc_d;
   logic          ovf_q,   ovf_d;
   logic          unf_q,   unf_d;
   logic          tick;

   assign tick = en && (pre_q == PRE_MAX);

   always_comb begin
      pre_d   = pre_q;
      count_d = count_q;
      tc_d    = 1'b0;
      ovf_d   = ovf_q;
      unf_d   = unf_q;

      // Clearing comes first so a same-edge boundary event below wins.
      if (clr_flags) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end

      if (load) begin
         count_d = (load_val > limit) ? limit : load_val;
         pre_d   = '0;
      end else if (en) begin
         pre_d = tick ? '0 : pre_q + 1'b1;
         if (tick) begin
            if (count_q > limit) begin
               // Limit was lowered under us: snap back into range silently.
               count_d = limit;
            end else if (up_down) begin
               if (count_q == limit) begin
                  count_d = mode ? limit : '0;
                  tc_d    = 1'b1;
                  ovf_d   = 1'b1;
               end else begin
                  count_d = count_q + 1'b1;
               end
            end else begin
               if (count_q == '0) begin
                  count_d = mode ? '0 : limit;
                  tc_d    = 1'b1;
                  unf_d   = 1'b1;
               end else begin
                  count_d = count_q - 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pre_q   <= '0;
         count_q <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         pre_q   <= pre_d;
         count_q <= count_d;
         tc_q    <= tc_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign count = count_q;
   assign tc    = tc_q;
   assign ovf   = ovf_q;
   assign unf   = unf_q;

endmodule

// File: tb/tb_mod_up_down_counter.sv
// Directed bench: one PRESCALE=1 and one PRESCALE=3 counter driven by shared stimulus.
module tb_mod_up_down_counter;

   logic       clk = 1'b0;
   logic       reset, en, up_down, mode, load, clr_flags;
   logic [7:0] load_val, limit;

   logic [7:0] d1_count, d3_count;
   logic       d1_tc, d1_ovf, d1_unf;
   logic       d3_tc, d3_ovf, d3_unf;

   int n_asrt = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mod_up_down_counter #(.N(8), .PRESCALE(1)) dut1 (
      .clk(clk), .reset(reset), .en(en), .up_down(up_down), .mode(mode),
      .load(load), .load_val(load_val), .limit(limit), .clr_flags(clr_flags),
      .count(d1_count), .tc(d1_tc), .ovf(d1_ovf), .unf(d1_unf)
   );

   mod_up_down_counter #(.N(8), .PRESCALE(3)) dut3 (
      .clk(clk), .reset(reset), .en(en), .up_down(up_down), .mode(mode),
      .load(load), .load_val(load_val), .limit(limit), .clr_flags(clr_flags),
      .count(d3_count), .tc(d3_tc), .ovf(d3_ovf), .unf(d3_unf)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      int exp32 [12];
      exp32 = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

      reset = 1'b1; en = 1'b0; up_down = 1'b1; mode = 1'b0; load = 1'b0;
      clr_flags = 1'b0; load_val = 8'd0; limit = 8'd9;
      cyc(); cyc();
      chk("rst_cnt", d1_count, 0);
      chk("rst_tc",  d1_tc,    0);
      chk("rst_ovf", d1_ovf,   0);
      chk("rst_unf", d1_unf,   0);
      chk("rst_cnt3", d3_count, 0);

      // Wrap up through limit 9.
      reset = 1'b0; en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cyc();
         chk("wrap_cnt", d1_count, exp32[i]);
         chk("wrap_tc",  d1_tc,    (i == 9) ? 1 : 0);
         chk("wrap_ovf", d1_ovf,   (i >= 9) ? 1 : 0);
      end

      // clr_flags alone, then clear coincident with an overflow.
      en = 1'b0; clr_flags = 1'b1;
      cyc();
      chk("clr_ovf", d1_ovf, 0);
      chk("clr_hold_cnt", d1_count, 2);
      clr_flags = 1'b0; load = 1'b1; load_val = 8'd9;
      cyc();
      chk("ld9_cnt", d1_count, 9);
      load = 1'b0; en = 1'b1; clr_flags = 1'b1;
      cyc();
      chk("coinc_cnt", d1_count, 0);
      chk("coinc_tc",  d1_tc,    1);
      chk("coinc_ovf", d1_ovf,   1);
      en = 1'b0;
      cyc();
      chk("clr2_ovf", d1_ovf, 0);
      chk("clr2_tc",  d1_tc,  0);
      clr_flags = 1'b0;

      // Load clamps to limit and suppresses the step.
      load = 1'b1; load_val = 8'd200; limit = 8'd100; en = 1'b1; mode = 1'b1; up_down = 1'b1;
      cyc();
      chk("ldclamp_cnt", d1_count, 100);
      chk("ldclamp_tc",  d1_tc,    0);
      chk("ldclamp_ovf", d1_ovf,   0);
      load = 1'b0;
      cyc();
      chk("sat_cnt", d1_count, 100);
      chk("sat_tc",  d1_tc,    1);
      chk("sat_ovf", d1_ovf,   1);
      en = 1'b0;
      cyc();
      chk("hold_cnt", d1_count, 100);
      chk("hold_tc",  d1_tc,    0);
      chk("hold_ovf", d1_ovf,   1);

      // Limit lowered below the count.
      load = 1'b1; load_val = 8'd50; mode = 1'b0;
      cyc();
      chk("ld50_cnt", d1_count, 50);
      load = 1'b0; limit = 8'd20; en = 1'b1; up_down = 1'b0;
      cyc();
      chk("snap_cnt", d1_count, 20);
      chk("snap_tc",  d1_tc,    0);
      chk("snap_unf", d1_unf,   0);
      up_down = 1'b1;
      cyc();
      chk("wrap20_cnt", d1_count, 0);
      chk("wrap20_tc",  d1_tc,    1);
      up_down = 1'b0;
      cyc();
      chk("dnwrap_cnt", d1_count, 20);
      chk("dnwrap_tc",  d1_tc,    1);
      chk("dnwrap_unf", d1_unf,   1);

      // limit = 0: snap, then every tick is a boundary.
      limit = 8'd0; up_down = 1'b1;
      cyc();
      chk("lim0_snap_cnt", d1_count, 0);
      chk("lim0_snap_tc",  d1_tc,    0);
      cyc();
      chk("lim0_cnt", d1_count, 0);
      chk("lim0_tc",  d1_tc,    1);

      // Reset during a tick at count == limit.
      en = 1'b0; limit = 8'd9; load = 1'b1; load_val = 8'd9;
      cyc();
      load = 1'b0; en = 1'b1; reset = 1'b1;
      cyc();
      chk("rstt_cnt", d1_count, 0);
      chk("rstt_tc",  d1_tc,    0);
      chk("rstt_ovf", d1_ovf,   0);
      chk("rstt_unf", d1_unf,   0);

      // PRESCALE=3 saturating down from 0, with an en gap mid-period.
      reset = 1'b0; limit = 8'd255; mode = 1'b1; up_down = 1'b0; en = 1'b1;
      cyc();
      chk("p3_e1_tc", d3_tc, 0);
      chk("p1_e1_tc", d1_tc, 1);
      chk("p1_e1_unf", d1_unf, 1);
      cyc();
      chk("p3_e2_tc", d3_tc, 0);
      cyc();
      chk("p3_e3_tc",  d3_tc,    1);
      chk("p3_e3_unf", d3_unf,   1);
      chk("p3_e3_cnt", d3_count, 0);
      cyc();
      chk("p3_e4_tc", d3_tc, 0);
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("p3_gap_tc",  d3_tc,    0);
         chk("p3_gap_cnt", d3_count, 0);
         chk("p3_gap_unf", d3_unf,   1);
      end
      en = 1'b1;
      cyc();
      chk("p3_e5_tc", d3_tc, 0);
      cyc();
      chk("p3_e6_tc",  d3_tc,    1);
      chk("p3_e6_cnt", d3_count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
